branch_control_sequencer: RTL and testbench
===========================================

BRANCH_CONTROL_SEQUENCER -- requirements
Module: branch_control_sequencer

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, datapath/bus width.
REQ-002 SHALL provide parameter WAIT_STATES, default 0, extra memory-read cycles held in T1 (range 0-15).
REQ-003 SHALL provide parameter BR_OPCODE, default 5'b10011, branch opcode in ir[DATA_WIDTH-1:DATA_WIDTH-5].
REQ-004 SHALL provide parameter ALU_INC, default 5'd12, and ALU_ADD, default 5'd2, ALU operation codes.
REQ-005 SHALL have one clock; reset is asynchronous and active-high. Ports: clk (in, 1, clock) and clr (in, 1, reset).
REQ-006 SHALL have ports start (in, 1, begin fetch/branch sequence) and ir (in, DATA_WIDTH, instruction register contents).
REQ-007 SHALL have port bus_in (in, DATA_WIDTH, bus value used for condition evaluation).
REQ-008 SHALL have 1-bit outputs PCout, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout.
REQ-009 SHALL have outputs alu_op (5), busy (1), done (1), taken (1) and unsupported (1).

Function
REQ-010 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6. All outputs except unsupported are decoded from present state (Moore).
REQ-011 IDLE: all strobes 0, busy=0. start=1 at a clock edge moves the FSM to T0, otherwise it stays in IDLE.
REQ-012 T0: PCout, MARin and Zin are 1 and alu_op=ALU_INC. Next state is T1.
REQ-013 T1: Read and MDRin are 1 for 1+WAIT_STATES cycles. Zlowout and PCin are 1 only in the first T1 cycle. A 4-bit wait counter loads WAIT_STATES on T0->T1 and decrements each T1 cycle. T1 exits to T2 when the counter is 0.
REQ-014 T2: MDRout and IRin are 1. Next state is T3.
REQ-015 T3, when ir opcode == BR_OPCODE: Gra, Rout and CONin are 1. con_ff captures cond(bus_in, ir[20:19]) at the end of T3. Next state is T4.
REQ-016 cond encoding: 00 -> bus_in==0; 01 -> bus_in!=0; 10 -> bus_in[DATA_WIDTH-1]==0; 11 -> bus_in[DATA_WIDTH-1]==1.
REQ-017 T3, when the opcode does not match: no strobes. The next state is IDLE, and unsupported is a registered 1-cycle pulse in the following cycle. done is not asserted.
REQ-018 T4: PCout and Yin are 1. Next state is T5.
REQ-019 T5: Cout and Zin are 1 and alu_op=ALU_ADD. Next state is T6.
REQ-020 T6: Zlowout and PCin equal con_ff. taken=con_ff, done=1. Next state is IDLE.
REQ-021 alu_op SHALL be 0 in all states except T0 and T5.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 start is ignored outside IDLE. A start held high re-enters T0 one cycle after IDLE is reached.
REQ-024 Branch latency, start edge to done, SHALL be 7+WAIT_STATES cycles.
REQ-025 con_ff SHALL hold its value until the next T3 of a matching opcode.

Reset
REQ-026 clr=1 SHALL immediately force state IDLE, con_ff=0, wait counter=0 and unsupported=0, with all outputs 0, independent of clk.
REQ-027 When clr is asserted mid-sequence, the sequence is abandoned and done is not pulsed. After clr is released, the next start begins at T0.

Verification
REQ-028 brzr: WAIT_STATES=0, ir=32'h9B000019 (cond 00), bus_in=0 in T3. Required: T6 at cycle 7 with Zlowout=PCin=taken=done=1.
REQ-029 Same as REQ-028 with bus_in=32'h5. Required: T6 has Zlowout=PCin=taken=0 and done=1.
REQ-030 cond 11, bus_in=32'h80000000 -> taken=1. cond 10 with the same bus_in -> taken=0. cond 01, bus_in=1 -> taken=1.
REQ-031 WAIT_STATES=2. Required: Read=MDRin=1 for exactly 3 cycles, Zlowout/PCin=1 only in the first of them, done at cycle 9.
REQ-032 ir opcode 5'b00000. Required: no Gra/Rout/CONin in T3, unsupported=1 for one cycle, return to IDLE, done never 1.
REQ-033 clr pulsed during T4. Required: all outputs 0 within the same cycle. A following start gives a full sequence with correct taken.

Source files
------------

// File: rtl/branch_control_sequencer_if.sv
// rtl/branch_control_sequencer_if.sv - control-strobe bundle between the branch sequencer and its datapath
interface branch_control_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] bus_in;

    logic       PCout;
    logic       MARin;
    logic       Zin;
    logic       Zlowout;
    logic       PCin;
    logic       Read;
    logic       MDRin;
    logic       MDRout;
    logic       IRin;
    logic       Gra;
    logic       Rout;
    logic       CONin;
    logic       Yin;
    logic       Cout;
    logic [4:0] alu_op;
    logic       busy;
    logic       done;
    logic       taken;
    logic       unsupported;

    // Datapath side: issues start and presents ir/bus, consumes strobes.
    modport master (
        output start, ir, bus_in,
        input  PCout, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
        input  Gra, Rout, CONin, Yin, Cout, alu_op, busy, done, taken, unsupported
    );

    // Sequencer side.
    modport slave (
        input  start, ir, bus_in,
        output PCout, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
        output Gra, Rout, CONin, Yin, Cout, alu_op, busy, done, taken, unsupported
    );
endinterface

// File: rtl/branch_control_sequencer.sv
// rtl/branch_control_sequencer.sv - fetch plus conditional-branch control sequencer
module branch_control_sequencer #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         WAIT_STATES = 0,
    parameter logic [4:0] BR_OPCODE   = 5'b10011,
    parameter logic [4:0] ALU_INC     = 5'd12,
    parameter logic [4:0] ALU_ADD     = 5'd2
) (
    input  logic                      clk,
    input  logic                      clr,
    branch_control_sequencer_if.slave bus
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       con_ff;
    logic       unsup_q;
    logic       br_match;
    logic       cond;

    assign br_match = (bus.ir[DATA_WIDTH-1 -: 5] == BR_OPCODE);

    always_comb begin
        cond = 1'b0;
        case (bus.ir[20:19])
            2'b00:   cond = (bus.bus_in == '0);
            2'b01:   cond = (bus.bus_in != '0);
            2'b10:   cond = ~bus.bus_in[DATA_WIDTH-1];
            default: cond = bus.bus_in[DATA_WIDTH-1];
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            con_ff   <= 1'b0;
            unsup_q  <= 1'b0;
        end else begin
            unsup_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) state <= T0;
                T0: begin
                    state    <= T1;
                    wait_cnt <= WS;
                end
                // Memory read is held here until the wait counter drains.
                T1: begin
                    if (wait_cnt == 4'd0) state <= T2;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                T2: state <= T3;
                T3: begin
                    if (br_match) begin
                        con_ff <= cond;
                        state  <= T4;
                    end else begin
                        unsup_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                T4:      state <= T5;
                T5:      state <= T6;
                T6:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.PCout   = 1'b0;
        bus.MARin   = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zlowout = 1'b0;
        bus.PCin    = 1'b0;
        bus.Read    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Gra     = 1'b0;
        bus.Rout    = 1'b0;
        bus.CONin   = 1'b0;
        bus.Yin     = 1'b0;
        bus.Cout    = 1'b0;
        bus.alu_op  = 5'd0;
        bus.done    = 1'b0;
        bus.taken   = 1'b0;
        case (state)
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = ALU_INC;
            end
            T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                // The incremented PC is committed once, on the first read cycle.
                bus.Zlowout = (wait_cnt == WS);
                bus.PCin    = (wait_cnt == WS);
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                bus.Gra   = br_match;
                bus.Rout  = br_match;
                bus.CONin = br_match;
            end
            T4: begin
                bus.PCout = 1'b1;
                bus.Yin   = 1'b1;
            end
            T5: begin
                bus.Cout   = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = ALU_ADD;
            end
            T6: begin
                bus.Zlowout = con_ff;
                bus.PCin    = con_ff;
                bus.taken   = con_ff;
                bus.done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy        = (state != IDLE);
    assign bus.unsupported = unsup_q;

endmodule

// File: tb/tb_branch_control_sequencer.sv
// tb/tb_branch_control_sequencer.sv - directed self-checking bench for branch_control_sequencer
module tb_branch_control_sequencer;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_control_sequencer_if #(.DATA_WIDTH(32)) if0 ();
    branch_control_sequencer_if #(.DATA_WIDTH(32)) if1 ();

    branch_control_sequencer #(.DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (if0.slave)
    );

    branch_control_sequencer #(.DATA_WIDTH(32), .WAIT_STATES(2)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (if1.slave)
    );

    // {PCout MARin Zin Zlowout PCin Read MDRin MDRout IRin Gra Rout CONin Yin Cout, alu_op, busy done taken unsupported}
    wire [22:0] obs0 = {if0.PCout, if0.MARin, if0.Zin, if0.Zlowout, if0.PCin, if0.Read, if0.MDRin,
                        if0.MDRout, if0.IRin, if0.Gra, if0.Rout, if0.CONin, if0.Yin, if0.Cout,
                        if0.alu_op, if0.busy, if0.done, if0.taken, if0.unsupported};
    wire [22:0] obs1 = {if1.PCout, if1.MARin, if1.Zin, if1.Zlowout, if1.PCin, if1.Read, if1.MDRin,
                        if1.MDRout, if1.IRin, if1.Gra, if1.Rout, if1.CONin, if1.Yin, if1.Cout,
                        if1.alu_op, if1.busy, if1.done, if1.taken, if1.unsupported};

    localparam logic [22:0] E_IDLE = 23'd0;
    localparam logic [22:0] E_T0   = {14'b11100000000000, 5'd12, 4'b1000};
    localparam logic [22:0] E_T1F  = {14'b00011110000000, 5'd0,  4'b1000};
    localparam logic [22:0] E_T1   = {14'b00000110000000, 5'd0,  4'b1000};
    localparam logic [22:0] E_T2   = {14'b00000001100000, 5'd0,  4'b1000};
    localparam logic [22:0] E_T3B  = {14'b00000000011100, 5'd0,  4'b1000};
    localparam logic [22:0] E_T3N  = {14'b00000000000000, 5'd0,  4'b1000};
    localparam logic [22:0] E_T4   = {14'b10000000000010, 5'd0,  4'b1000};
    localparam logic [22:0] E_T5   = {14'b00100000000001, 5'd2,  4'b1000};
    localparam logic [22:0] E_T6T  = {14'b00011000000000, 5'd0,  4'b1110};
    localparam logic [22:0] E_T6N  = {14'b00000000000000, 5'd0,  4'b1100};
    localparam logic [22:0] E_UNS  = {14'b00000000000000, 5'd0,  4'b0001};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run_branch0(input logic [31:0] ir_v, input logic [31:0] bus_v,
                               input logic tk, input string tag);
        if0.ir     = ir_v;
        if0.bus_in = bus_v;
        if0.start  = 1'b1;
        tick();
        if0.start  = 1'b0;
        chk({tag, ".c1_t0"}, obs0, E_T0);
        tick(); chk({tag, ".c2_t1"}, obs0, E_T1F);
        tick(); chk({tag, ".c3_t2"}, obs0, E_T2);
        tick(); chk({tag, ".c4_t3"}, obs0, E_T3B);
        tick(); chk({tag, ".c5_t4"}, obs0, E_T4);
        tick(); chk({tag, ".c6_t5"}, obs0, E_T5);
        tick(); chk({tag, ".c7_t6"}, obs0, tk ? E_T6T : E_T6N);
        tick(); chk({tag, ".c8_idle"}, obs0, E_IDLE);
    endtask

    initial begin
        clr        = 1'b1;
        if0.start  = 1'b0;
        if0.ir     = 32'h0;
        if0.bus_in = 32'h0;
        if1.start  = 1'b0;
        if1.ir     = 32'h0;
        if1.bus_in = 32'h0;
        tick();
        chk("reset.dut0", obs0, E_IDLE);
        chk("reset.dut1", obs1, E_IDLE);
        clr = 1'b0;
        tick();
        chk("idle_no_start", obs0, E_IDLE);

        run_branch0(32'h9B000019, 32'h00000000, 1'b1, "brzr_taken");
        run_branch0(32'h9B000019, 32'h00000005, 1'b0, "brzr_not");
        run_branch0(32'h9B180019, 32'h80000000, 1'b1, "brmi_taken");
        run_branch0(32'h9B100019, 32'h80000000, 1'b0, "brpl_not");
        run_branch0(32'h9B080019, 32'h00000001, 1'b1, "brnz_taken");

        // Two wait states: three read cycles, done at cycle 9.
        if1.ir     = 32'h9B000019;
        if1.bus_in = 32'h00000000;
        if1.start  = 1'b1;
        tick();
        if1.start  = 1'b0;
        chk("ws2.c1_t0", obs1, E_T0);
        tick(); chk("ws2.c2_t1_first", obs1, E_T1F);
        tick(); chk("ws2.c3_t1", obs1, E_T1);
        tick(); chk("ws2.c4_t1", obs1, E_T1);
        tick(); chk("ws2.c5_t2", obs1, E_T2);
        tick(); chk("ws2.c6_t3", obs1, E_T3B);
        tick(); chk("ws2.c7_t4", obs1, E_T4);
        tick(); chk("ws2.c8_t5", obs1, E_T5);
        tick(); chk("ws2.c9_t6", obs1, E_T6T);
        tick(); chk("ws2.c10_idle", obs1, E_IDLE);

        // Unsupported opcode.
        if0.ir     = 32'h00000019;
        if0.bus_in = 32'h00000000;
        if0.start  = 1'b1;
        tick();
        if0.start  = 1'b0;
        chk("unsup.c1_t0", obs0, E_T0);
        tick(); chk("unsup.c2_t1", obs0, E_T1F);
        tick(); chk("unsup.c3_t2", obs0, E_T2);
        tick(); chk("unsup.c4_t3", obs0, E_T3N);
        tick(); chk("unsup.c5_pulse", obs0, E_UNS);
        tick(); chk("unsup.c6_idle", obs0, E_IDLE);

        // Start held high re-enters T0 one cycle after IDLE.
        if0.ir     = 32'h9B000019;
        if0.bus_in = 32'h00000005;
        if0.start  = 1'b1;
        tick(); chk("held.c1_t0", obs0, E_T0);
        tick(); chk("held.c2_t1", obs0, E_T1F);
        tick(); tick(); tick(); tick();
        tick(); chk("held.c7_t6", obs0, E_T6N);
        tick(); chk("held.c8_idle", obs0, E_IDLE);
        tick(); chk("held.c9_t0", obs0, E_T0);
        if0.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("held.drain_idle", obs0, E_IDLE);

        // Asynchronous clear during T4, then a clean sequence.
        if0.ir     = 32'h9B000019;
        if0.bus_in = 32'h00000000;
        if0.start  = 1'b1;
        tick();
        if0.start  = 1'b0;
        tick(); tick(); tick();
        tick(); chk("clr.c5_t4", obs0, E_T4);
        clr = 1'b1;
        #1;
        chk("clr.async_zero", obs0, E_IDLE);
        tick(); chk("clr.held", obs0, E_IDLE);
        clr = 1'b0;
        tick(); chk("clr.released_idle", obs0, E_IDLE);
        run_branch0(32'h9B180019, 32'h80000000, 1'b1, "after_clr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
